// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered result/flag FIFO behind the 32-bit ALUs with a
//               valid/ready writeback port, a sticky flag register (built only
//               when ALU_RES_STICKY_EN is defined) and a saturating op counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_opcode,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       sticky_flags,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count,
    output logic             overflow_err
);

    localparam int               c_AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [3:0]         r_mem_opcode [DEPTH];
    logic [WIDTH-1:0]   r_mem_result [DEPTH];
    logic [3:0]         r_mem_flags  [DEPTH];
    logic [CNT_W-1:0]   r_op_count;
    logic               r_overflow_err;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_AW-1:0]    w_rd_idx;
    logic [c_AW-1:0]    w_wr_idx;

    // Full/empty come from registered pointers only, so in_ready never sees out_ready.
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign in_ready = !w_full;
    assign out_valid = !w_empty;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;
    assign w_rd_idx = r_rd_ptr[c_AW-1:0];
    assign w_wr_idx = r_wr_ptr[c_AW-1:0];

    assign out_opcode   = out_valid ? r_mem_opcode[w_rd_idx] : 4'd0;
    assign out_result   = out_valid ? r_mem_result[w_rd_idx] : '0;
    assign out_flags    = out_valid ? r_mem_flags[w_rd_idx]  : 4'd0;
    assign op_count     = r_op_count;
    assign overflow_err = r_overflow_err;

    // Storage needs no reset: stale entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_opcode[w_wr_idx] <= in_opcode;
            r_mem_result[w_wr_idx] <= in_result;
            r_mem_flags[w_wr_idx]  <= in_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_op_count     <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && (r_op_count != c_CNT_MAX)) begin
                r_op_count <= r_op_count + 1'b1;
            end
            if (in_valid && !in_ready) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

`ifdef ALU_RES_STICKY_EN
    logic [3:0] r_sticky;

    // Clear takes effect first, so a same-cycle push leaves exactly its flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 4'd0;
        end else if (sticky_clr) begin
            r_sticky <= w_push ? in_flags : 4'd0;
        end else if (w_push) begin
            r_sticky <= r_sticky | in_flags;
        end
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused;

    assign w_unused     = &{1'b0, sticky_clr};
    assign sticky_flags = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage (vector table plus
//               streaming, wrap-around and asynchronous reset sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  sticky_flags;
    logic        sticky_clr;
    logic [15:0] op_count;
    logic        overflow_err;

    // Narrow-counter instance shares the stimulus; only its counter is checked.
    logic        n_in_ready;
    logic        n_out_valid;
    logic [3:0]  n_out_opcode;
    logic [31:0] n_out_result;
    logic [3:0]  n_out_flags;
    logic [3:0]  n_sticky_flags;
    logic [3:0]  n_op_count;
    logic        n_overflow_err;

    int n_pass  = 0;
    int n_total = 0;

    alu_result_stage #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_result(in_result), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_result(out_result), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
        .op_count(op_count), .overflow_err(overflow_err)
    );

    alu_result_stage #(.WIDTH(32), .DEPTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_opcode(in_opcode),
        .in_result(in_result), .in_flags(in_flags),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_opcode(n_out_opcode),
        .out_result(n_out_result), .out_flags(n_out_flags),
        .sticky_flags(n_sticky_flags), .sticky_clr(sticky_clr),
        .op_count(n_op_count), .overflow_err(n_overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [3:0]  op;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        ordy;
        logic        clr;
        logic        e_ov;
        logic        e_ir;
        logic [3:0]  e_op;
        logic [31:0] e_res;
        logic [3:0]  e_fl;
        logic [15:0] e_cnt;
        logic [3:0]  e_st;
        logic        e_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] st_exp(input logic [3:0] v);
`ifdef ALU_RES_STICKY_EN
        return v;
`else
        return 4'd0 & v;
`endif
    endfunction

    initial begin
        // inputs: iv op res fl ordy clr | expected after edge: ov ir op res fl cnt sticky err
        vecs[0]  = '{1'b1, 4'd0, 32'd5, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 32'd5, 4'b0000, 16'd1, 4'b0000, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 4'b0000, 16'd1, 4'b0000, 1'b0};
        vecs[2]  = '{1'b1, 4'd1, 32'd1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'd1, 4'b0100, 16'd2, 4'b0100, 1'b0};
        vecs[3]  = '{1'b1, 4'd2, 32'd2, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'd1, 4'b0100, 16'd3, 4'b0101, 1'b0};
        vecs[4]  = '{1'b1, 4'd3, 32'd3, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'd1, 4'b0100, 16'd4, 4'b0101, 1'b0};
        vecs[5]  = '{1'b1, 4'd4, 32'd4, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'd1, 4'b0100, 16'd5, 4'b0101, 1'b0};
        vecs[6]  = '{1'b1, 4'd5, 32'd5, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'd1, 4'b0100, 16'd5, 4'b0101, 1'b1};
        vecs[7]  = '{1'b0, 4'd0, 32'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'd2, 4'b0001, 16'd5, 4'b0101, 1'b1};
        vecs[8]  = '{1'b0, 4'd0, 32'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 32'd3, 4'b0000, 16'd5, 4'b0101, 1'b1};
        vecs[9]  = '{1'b0, 4'd0, 32'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 32'd4, 4'b0000, 16'd5, 4'b0101, 1'b1};
        vecs[10] = '{1'b1, 4'd6, 32'd6, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 32'd6, 4'b1000, 16'd6, 4'b1000, 1'b1};
        vecs[11] = '{1'b0, 4'd0, 32'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 4'b0000, 16'd6, 4'b0000, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_result = '0; in_flags = '0;
        out_ready = 1'b0; sticky_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_result", 64'(out_result), 64'd0);
        check("reset op_count", 64'(op_count), 64'd0);
        check("reset overflow_err", 64'(overflow_err), 64'd0);
        check("reset sticky", 64'(sticky_flags), 64'd0);

        for (int i = 0; i < 12; i++) begin
            in_valid = vecs[i].iv; in_opcode = vecs[i].op; in_result = vecs[i].res;
            in_flags = vecs[i].fl; out_ready = vecs[i].ordy; sticky_clr = vecs[i].clr;
            step();
            check($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            check($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            check($sformatf("row%0d out_opcode", i), 64'(out_opcode), 64'(vecs[i].e_op));
            check($sformatf("row%0d out_result", i), 64'(out_result), 64'(vecs[i].e_res));
            check($sformatf("row%0d out_flags", i), 64'(out_flags), 64'(vecs[i].e_fl));
            check($sformatf("row%0d op_count", i), 64'(op_count), 64'(vecs[i].e_cnt));
            check($sformatf("row%0d sticky", i), 64'(sticky_flags), 64'(st_exp(vecs[i].e_st)));
            check($sformatf("row%0d overflow_err", i), 64'(overflow_err), 64'(vecs[i].e_err));
        end
        sticky_clr = 1'b0;

        // Asynchronous reset with three entries buffered
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_opcode = 4'(k); in_result = 32'hA0 + k; in_flags = 4'b0010;
            step();
        end
        in_valid = 1'b0;
        check("pre-rst out_valid", 64'(out_valid), 64'd1);
        check("pre-rst op_count", 64'(op_count), 64'd9);
        check("pre-rst sticky", 64'(sticky_flags), 64'(st_exp(4'b0010)));
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst in_ready", 64'(in_ready), 64'd1);
        check("async rst out_result", 64'(out_result), 64'd0);
        check("async rst op_count", 64'(op_count), 64'd0);
        check("async rst overflow_err", 64'(overflow_err), 64'd0);
        check("async rst sticky", 64'(sticky_flags), 64'd0);
        rst = 1'b0;
        step();

        // Streaming: 100 back-to-back pushes with the consumer always ready
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_valid = 1'b1; in_opcode = 4'(k); in_result = 32'h1000 + k; in_flags = 4'b0000;
            step();
            check($sformatf("stream%0d out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("stream%0d out_result", k), 64'(out_result), 64'(32'h1000 + k));
        end
        in_valid = 1'b0;
        step();
        check("stream drained out_valid", 64'(out_valid), 64'd0);
        check("stream op_count", 64'(op_count), 64'd100);
        check("narrow op_count saturated", 64'(n_op_count), 64'd15);

        // Wrap-around with occupancy held at 2 under simultaneous push/pop
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_opcode = 4'(k); in_result = 32'h2000 + k;
            step();
        end
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_opcode = 4'(k + 2); in_result = 32'h2000 + k + 2;
            step();
            check($sformatf("wrap%0d head", k), 64'(out_result), 64'(32'h2000 + k + 1));
            check($sformatf("wrap%0d in_ready", k), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("wrap drain head", 64'(out_result), 64'(32'h200B));
        check("wrap drain valid", 64'(out_valid), 64'd1);
        step();
        check("wrap empty", 64'(out_valid), 64'd0);
        check("wrap op_count", 64'(op_count), 64'd112);
        check("narrow op_count held", 64'(n_op_count), 64'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result/flag buffer that sits directly downstream of the generated 32-bit combinational ALUs. It captures each ALU result with its opcode and carry/zero/overflow/sign flags into a small FIFO, presents them to the writeback consumer over a valid/ready handshake, and keeps a sticky flag status register and an accepted-operation counter for software inspection.

## Interface
- `WIDTH`, 32: result width; must match the upstream ALU bit width.
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CNT_W`, 16: width of the accepted-operation counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream ALU output is valid this cycle.
- `in_ready` out 1: stage can accept; equals `!full`; depends on registered state only.
- `in_opcode` in 4: opcode that produced the result.
- `in_result` in WIDTH: ALU result.
- `in_flags` in 4: packed as {carry, zero, overflow, sign}, bits [3:0].
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer accepts the head entry.
- `out_opcode` out 4: opcode of the head entry.
- `out_result` out WIDTH: result of the head entry.
- `out_flags` out 4: flags of the head entry, same packing.
- `sticky_flags` out 4: OR of the flags of all entries accepted since the last clear.
- `sticky_clr` in 1: synchronous clear of `sticky_flags`.
- `op_count` out CNT_W: number of accepted inputs; saturates at all-ones.
- `overflow_err` out 1: sticky; set when `in_valid` is high while `in_ready` is low; cleared only by reset.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- The FIFO is a circular buffer with read and write pointers of width log2(DEPTH)+1. Full means the pointer MSBs differ and the low bits are equal. Empty means the pointers are equal. Pointers wrap naturally.
- `out_*` fields are driven from the registered head entry. When `out_valid` is low, `out_opcode`, `out_result` and `out_flags` are 0.
- Push and pop in the same cycle, not empty: both take effect and the occupancy is unchanged.
- Push and pop in the same cycle, empty: not possible, because `out_valid` is 0 when empty.
- When full, `in_ready` is 0 even if `out_ready` is 1. There is no combinational path from `out_ready` to `in_ready`.
- A push with `in_valid` while full is dropped and sets `overflow_err`. This is a protocol violation flag only.
- Sticky flags: on push, `sticky_flags |= in_flags`. When `sticky_clr` and a push occur in the same cycle, the result is `in_flags`: the clear applies first, then the new flags are set.
- `op_count` increments by 1 per push and holds at 2^CNT_W−1.
- Reset values: all pointers 0, `out_valid` 0, `in_ready` 1, `out_opcode`/`out_result`/`out_flags` 0, `sticky_flags` 0, `op_count` 0, `overflow_err` 0.
- Reset mid-operation: all buffered entries are discarded immediately, asynchronously.

## Timing
- Latency from input to output is 1 cycle. An entry pushed at edge N is visible with `out_valid` high after edge N.
- Throughput is 1 entry per cycle sustained while the consumer holds `out_ready` high.
- Sticky and counter updates are visible 1 cycle after the push edge.
- `in_ready` and `out_valid` are purely registered-state functions. Each is valid early in the cycle.

## Configuration
- `ALU_RES_STICKY_EN` defined: the sticky flag register and `sticky_clr` behave as described above.
- `ALU_RES_STICKY_EN` undefined: the sticky register is not built. `sticky_flags` is constant 0 and `sticky_clr` is ignored. All other behaviour is identical.

## Test plan
- Reset then single op: push opcode 0, result 0x0000_0005, flags 4'b0000 → next cycle `out_valid`=1, `out_result`=5. With `out_ready`=1, the pop leaves the FIFO empty and `op_count`=1.
- Fill to full: DEPTH=4, `out_ready`=0, push 4 entries 1..4 → `in_ready`=0 after the 4th. A 5th `in_valid` sets `overflow_err`=1 and entries pop out in order as 1,2,3,4.
- Streaming: 100 back-to-back pushes with `out_ready`=1 → `out_valid` stays high from cycle 1, no bubbles, data in order, `op_count`=100.
- Sticky flags: push flags 4'b0100 then 4'b0001 → `sticky_flags`=4'b0101. Assert `sticky_clr` with a push of 4'b1000 in the same cycle → `sticky_flags`=4'b1000.
- Wrap-around and simultaneous push/pop: keep occupancy at 2 while running 10 push+pop cycles → pointers wrap and occupancy stays 2 with data in order. With CNT_W=4, 20 pushes → `op_count`=15.
- Reset mid-operation: 3 entries buffered, assert `rst` asynchronously mid-cycle → `out_valid`=0, `in_ready`=1, counters and flags 0 immediately.
